inv_sub_bytes_iter: RTL and testbench
=====================================

# inv_sub_bytes_iter

- Iterative AES InvSubBytes unit for the composite-field datapath.
- Accepts a 128-bit state over a valid/ready handshake and substitutes one or more 32-bit columns per cycle.
- Each byte passes through the inverse affine transform, then a GF(2^8) multiplicative inverse.
- Returns the 128-bit result over a second valid/ready handshake; sits in the decryption round between InvShiftRows and AddRoundKey.

## Interface
- `WORDS_PER_CYCLE`, default 1: columns substituted per cycle. Legal values are 1, 2, 4. Any other value is an elaboration error.
- `clk`  in  1  clock.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `in_valid`  in  1  input state valid.
- `in_ready`  out  1  unit can accept a state.
- `in_state`  in  128  ciphertext-side state; column 0 = [127:96], byte order within a column MSB-first.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_state`  out  128  substituted state, same byte layout as `in_state`.
- `busy`  out  1  high in BUSY or DONE.

## Operation
- Per byte b:
  - Inverse affine: a_i = b_(i+2 mod 8) ^ b_(i+5 mod 8) ^ b_(i+7 mod 8) ^ c_i, with c = 8'h05.
  - Then result = GF(2^8) inverse of a, modulo x^8+x^4+x^3+x+1, with inverse(0) = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1. When `in_valid`: load `in_state` into the state register, clear the column counter, go to BUSY.
  - BUSY: each cycle, replace columns [cnt .. cnt+WORDS_PER_CYCLE-1] in place, then cnt += WORDS_PER_CYCLE. After the last column group, go to DONE.
  - DONE: `out_valid`=1 and `out_state` = state register. When `out_ready`, go to IDLE.
- Counter:
  - 2 bits wide; wraps to 0 when leaving BUSY.
  - Columns are processed in ascending order: 0, then 1, 2, 3.
- Outputs are stable while `out_valid` is high and `out_ready` is low. `out_state` holds its value after the handshake until the next load.
- `in_valid` outside IDLE is ignored, with `in_ready` low. No input is queued.
- `in_state` is sampled only on the accept edge. Later changes to the input have no effect.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_state` = 128'h0; counter = 0.
- Latency: with accept in cycle c0, `out_valid` first rises in cycle c0 + 4/WORDS_PER_CYCLE + 1. That is cycle 5, 3 or 2 for W = 1, 2, 4.
- Throughput: one state per 4/W + 2 cycles when `out_ready` is tied high. `in_ready` returns the cycle after the output handshake.
- `in_ready`, `out_valid` and `busy` are pure decodes of the state register, with no combinational path from inputs.
- `rst` during BUSY or DONE aborts the operation at the next edge. All outputs return to their reset values and the partial result is discarded.
- `rst` and `in_valid` in the same cycle: reset wins and nothing is loaded.
- The GF inverse is combinational within one cycle. Timing closure targets one column group of logic.

## Structure
- Shared package `aes_pkg` holds:
  - The inverse affine constant 8'h05 and the field polynomial 9'h11B.
  - The FSM state enum.
  - The `inv_affine_8` function.
- Sub-module `inv_sbox_8`: inverse affine followed by the existing `GF_MULINV_8`. The unit instantiates it 4×WORDS_PER_CYCLE times.
- The top level contains only the FSM, counter, column mux and state register.

## Test plan
- FIPS-197 vector, W=1: `in_state`=d42711aee0bf98f1b8b45de51e415230 → `out_state`=193de3bea0f4e22b9ac68d2ae9f84808, `out_valid` exactly 5 cycles after accept.
- Byte corners, run for W=1, 2 and 4 (latencies 5, 3, 2):
  - Input all bytes 8'h63 → all 8'h00.
  - Input all 8'h00 → all 8'h52.
  - Input all 8'h7C → all 8'h01.
  - Input all 8'hED → all 8'h53.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. `out_state` must stay constant, `in_ready` stays 0, and an `in_valid` pulse during that time is ignored. Then release → `in_ready`=1 on the next cycle.
- Reset mid-op: assert `rst` in the 2nd BUSY cycle. Next cycle `out_valid`=0, `in_ready`=1, `out_state`=0. A following vector then completes correctly.
- Exhaustive: for all 256 byte values broadcast to 16 bytes, the output equals the inverse S-box table. Back-to-back runs with `out_ready`=1 give one result every 4/W+2 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decryption definitions.
// Field constants, FSM states and the inverse affine map.
package aes_pkg;

  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [8:0] GF_POLY      = 9'h11B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // a = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ c
  function automatic logic [7:0] inv_affine_8(
    input logic [7:0] b
  );
    logic [7:0] r1, r3, r6;
    r1 = {b[6:0], b[7]};
    r3 = {b[4:0], b[7:5]};
    r6 = {b[1:0], b[7:2]};
    return r1 ^ r3 ^ r6 ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/gf_mulinv_8.sv
// GF(2^8) multiplicative inverse, x^254 addition chain.
// Zero maps to zero naturally.
module GF_MULINV_8
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, aa, bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      bb = bb >> 1;
      if (aa[7]) aa = (aa << 1) ^ GF_POLY[7:0];
      else       aa = aa << 1;
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15;
  logic [7:0] x30, x31, x62, x63, x126, x127;

  assign x2   = gmul(in_byte, in_byte);
  assign x3   = gmul(x2, in_byte);
  assign x6   = gmul(x3, x3);
  assign x7   = gmul(x6, in_byte);
  assign x14  = gmul(x7, x7);
  assign x15  = gmul(x14, in_byte);
  assign x30  = gmul(x15, x15);
  assign x31  = gmul(x30, in_byte);
  assign x62  = gmul(x31, x31);
  assign x63  = gmul(x62, in_byte);
  assign x126 = gmul(x63, x63);
  assign x127 = gmul(x126, in_byte);
  assign out_byte = gmul(x127, x127);

endmodule

// File: rtl/inv_sbox_8.sv
// One-byte inverse S-box.
// Inverse affine first, then field inversion.
module inv_sbox_8
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] aff;

  assign aff = inv_affine_8(in_byte);

  GF_MULINV_8 u_inv (
    .in_byte  (aff),
    .out_byte (out_byte)
  );

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes over a 128-bit state.
// Substitutes WORDS_PER_CYCLE columns per cycle.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(WORDS_PER_CYCLE == 1 ||
        WORDS_PER_CYCLE == 2 ||
        WORDS_PER_CYCLE == 4)) begin : g_bad_w
    $error("WORDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(WORDS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - WORDS_PER_CYCLE);
  localparam logic [2:0] W3   = 3'(WORDS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;

  logic [31:0] cols    [4];
  logic [31:0] grp_out [4];
  logic [31:0] col_nxt [4];

  for (genvar j = 0; j < 4; j++) begin : g_col
    logic [1:0] off;
    logic       hit;
    assign cols[j]    = data_q[127-32*j -: 32];
    assign off        = 2'(j) - cnt_q;
    assign hit        = {1'b0, off} < W3;
    assign col_nxt[j] = hit ? grp_out[off] : cols[j];
  end

  for (genvar k = 0; k < 4; k++) begin : g_grp
    if (k < WORDS_PER_CYCLE) begin : g_on
      logic [1:0]  idx;
      logic [31:0] sb_in, sb_out;
      assign idx   = cnt_q + 2'(k);
      assign sb_in = cols[idx];
      for (genvar b = 0; b < 4; b++) begin : g_byte
        inv_sbox_8 u_sbox (
          .in_byte  (sb_in[31-8*b -: 8]),
          .out_byte (sb_out[31-8*b -: 8])
        );
      end
      assign grp_out[k] = sb_out;
    end else begin : g_off
      assign grp_out[k] = '0;
    end
  end

  // Next state: load, step one column group, or hand off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_state;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        data_d = {col_nxt[0], col_nxt[1],
                  col_nxt[2], col_nxt[3]};
        cnt_d  = cnt_q + STEP;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_state = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter.
// Runs W=1, 2 and 4 side by side on shared inputs.
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
  logic [2:0]   ir, ov, bz;
  logic [127:0] os [3];

  int checks = 0;
  int errors = 0;

  int lat_exp [3] = '{5, 3, 2};
  int per_exp [3] = '{6, 4, 3};

  localparam logic [127:0] FIPS_IN  =
    128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT =
    128'h193de3bea0f4e22b9ac68d2ae9f84808;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.WORDS_PER_CYCLE(1)) u_w1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_state(in_state),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_state(os[0]), .busy(bz[0])
  );

  inv_sub_bytes_iter #(.WORDS_PER_CYCLE(2)) u_w2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_state(in_state),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_state(os[1]), .busy(bz[1])
  );

  inv_sub_bytes_iter #(.WORDS_PER_CYCLE(4)) u_w4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir[2]),
    .in_state(in_state),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_state(os[2]), .busy(bz[2])
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Carry-less product, then reduction by 0x11B.
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[3'(i)]) prod = prod ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (prod[4'(k)]) prod = prod ^ (16'h011B << (k - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] inv_aff(
    input logic [7:0] b
  );
    logic [7:0] a;
    logic [7:0] c;
    a = '0;
    c = 8'h05;
    for (int i = 0; i < 8; i++)
      a[3'(i)] = b[3'(i + 2)] ^ b[3'(i + 5)] ^
                 b[3'(i + 7)] ^ c[3'(i)];
    return a;
  endfunction

  // y is the inverse S-box of x iff inv_aff(x) * y == 1.
  function automatic logic prop_ok(
    input logic [127:0] x,
    input logic [127:0] y
  );
    logic       ok;
    logic [7:0] a, yb;
    ok = 1'b1;
    for (int p = 0; p < 16; p++) begin
      a  = inv_aff(x[8*p +: 8]);
      yb = y[8*p +: 8];
      if (a == 8'h00) ok = ok & (yb == 8'h00);
      else            ok = ok & (gmul(a, yb) == 8'h01);
    end
    return ok;
  endfunction

  task automatic run_vec(
    input logic [127:0] x,
    input logic [127:0] e,
    input logic         prop,
    input string        tag
  );
    int           lat [3];
    logic [127:0] got [3];
    lat = '{0, 0, 0};
    got = '{default: '0};
    in_state  = x;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = ~x;
    for (int n = 1; n <= 12; n++) begin
      for (int i = 0; i < 3; i++)
        if (lat[i] == 0 && ov[2'(i)]) begin
          lat[i] = n;
          got[i] = os[i];
        end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0)
        break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_lat_u%0d", tag, i),
          128'(lat[i]), 128'(lat_exp[i]));
      if (prop)
        chk($sformatf("%s_prop_u%0d %h", tag, i, got[i]),
            128'(prop_ok(x, got[i])), 128'd1);
      else
        chk($sformatf("%s_data_u%0d", tag, i), got[i], e);
    end
  endtask

  initial begin : main
    int last [3];
    int nrise [3];
    logic [2:0] ov_prev;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_state  = '0;
    @(posedge clk); #1;
    chk("rst_in_ready",  128'(ir), 128'h7);
    chk("rst_out_valid", 128'(ov), 128'h0);
    chk("rst_busy",      128'(bz), 128'h0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_out_state_u%0d", i), os[i], '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec(FIPS_IN, FIPS_OUT, 1'b0, "fips");
    run_vec({16{8'h63}}, {16{8'h00}}, 1'b0, "c63");
    run_vec({16{8'h00}}, {16{8'h52}}, 1'b0, "c00");
    run_vec({16{8'h7C}}, {16{8'h01}}, 1'b0, "c7c");
    run_vec({16{8'hED}}, {16{8'h53}}, 1'b0, "ced");

    // Backpressure with an ignored in_valid pulse.
    out_ready = 1'b0;
    in_state  = FIPS_IN;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = '0;
    for (int n = 0; n < 10; n++) begin
      if (ov == 3'b111) break;
      @(posedge clk); #1;
    end
    chk("bp_all_valid", 128'(ov), 128'h7);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_in_ready_c%0d", c), 128'(ir), 128'h0);
      chk($sformatf("bp_valid_c%0d", c),    128'(ov), 128'h7);
      chk($sformatf("bp_busy_c%0d", c),     128'(bz), 128'h7);
      for (int i = 0; i < 3; i++)
        chk($sformatf("bp_data_c%0d_u%0d", c, i), os[i], FIPS_OUT);
      in_valid = (c == 3);
      in_state = {16{8'h63}};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_in_ready", 128'(ir), 128'h7);
    chk("bp_rel_valid",    128'(ov), 128'h0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_hold_u%0d", i), os[i], FIPS_OUT);

    // Reset in the second BUSY cycle.
    in_state = {16{8'hED}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid",    128'(ov), 128'h0);
    chk("mid_rst_in_ready", 128'(ir), 128'h7);
    chk("mid_rst_busy",     128'(bz), 128'h0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("mid_rst_data_u%0d", i), os[i], '0);

    // Reset and in_valid together: nothing loaded.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_state = {16{8'h63}};
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_valid_in_ready", 128'(ir), 128'h7);
    chk("rst_vs_valid_busy",     128'(bz), 128'h0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_vs_valid_u%0d", i), os[i], '0);

    run_vec(FIPS_IN, FIPS_OUT, 1'b0, "post_rst");

    // Every byte value broadcast to all 16 bytes.
    for (int v = 0; v < 256; v++)
      run_vec({16{8'(v)}}, '0, 1'b1, $sformatf("ex%02h", v));

    // Back-to-back throughput with in_valid held high.
    last     = '{0, 0, 0};
    nrise    = '{0, 0, 0};
    ov_prev  = ov;
    in_state = {16{8'h7C}};
    in_valid = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (ov[2'(i)] && !ov_prev[2'(i)]) begin
          if (nrise[i] > 0)
            chk($sformatf("tput_u%0d_t%0d", i, t),
                128'(t - last[i]), 128'(per_exp[i]));
          chk($sformatf("tput_data_u%0d_t%0d", i, t),
              os[i], {16{8'h01}});
          last[i] = t;
          nrise[i]++;
        end
      ov_prev = ov;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("tput_count_u%0d", i),
          128'(nrise[i] >= 3), 128'd1);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
    end
    chk("final_idle", 128'(ir), 128'h7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
